// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline definitions: one-hot ALU forward selects, stage tag layout and the
// hard-wired zero register, consumed by the hazard unit and the ALU input mux.
package forwarding_hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam int SEL_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [SEL_W-1:0] {
    SEL_ID_EX   = 5'b00001,
    SEL_EXM_TOP = 5'b00010,
    SEL_EXM_BOT = 5'b00100,
    SEL_MWB_TOP = 5'b01000,
    SEL_MWB_BOT = 5'b10000
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst_top;
    logic             dst_top_vld;
    logic [REG_W-1:0] dst_bot;
    logic             dst_bot_vld;
    logic             is_load;
  } stage_tag_t;

  localparam stage_tag_t TAG_EMPTY = '0;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_match.sv
// Compares one ID source register against one stage tag and returns the forward
// select for that stage plus a hit flag.
module fwd_match
  import forwarding_hazard_unit_pkg::*;
#(
  parameter fwd_sel_e SEL_TOP = SEL_EXM_TOP,
  parameter fwd_sel_e SEL_BOT = SEL_EXM_BOT
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_vld,
  input  stage_tag_t       tag,
  output fwd_sel_e         sel,
  output logic             hit
);

  logic active;
  logic top_hit;
  logic bot_hit;

  assign active  = src_vld && (src != REG_ZERO) && tag.valid;
  assign top_hit = active && tag.dst_top_vld && (tag.dst_top == src);
  assign bot_hit = active && tag.dst_bot_vld && (tag.dst_bot == src);
  assign hit     = top_hit || bot_hit;

  // The bottom half is written after the top half, so it wins when both name src.
  assign sel = bot_hit ? SEL_BOT : (top_hit ? SEL_TOP : SEL_ID_EX);

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Load-use stall and operand-forward select generation for a 2-half-result pipeline;
// keeps EX/MEM/WB shadow tags and registers the ALU selects into EX.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_top,
  input  logic             id_src_top_vld,
  input  logic [REG_W-1:0] id_src_bot,
  input  logic             id_src_bot_vld,
  input  logic [REG_W-1:0] id_dst_top,
  input  logic             id_dst_top_vld,
  input  logic [REG_W-1:0] id_dst_bot,
  input  logic             id_dst_bot_vld,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_hold,
  output logic [SEL_W-1:0] alu_top_sel,
  output logic [SEL_W-1:0] alu_bot_sel,
  output logic             stall,
  output logic             bubble
);

  stage_tag_t ex_tag, mem_tag, wb_tag;
  stage_tag_t id_tag;
  fwd_sel_e   top_sel_q, bot_sel_q;
  fwd_sel_e   top_sel_d, bot_sel_d;
  fwd_sel_e   ex_top_sel, ex_bot_sel, mem_top_sel, mem_bot_sel;
  logic       ex_top_hit, ex_bot_hit, mem_top_hit, mem_bot_hit;

  assign id_tag = '{valid:       1'b1,
                    dst_top:     id_dst_top,
                    dst_top_vld: id_dst_top_vld,
                    dst_bot:     id_dst_bot,
                    dst_bot_vld: id_dst_bot_vld,
                    is_load:     id_is_load};

  fwd_match #(.SEL_TOP(SEL_EXM_TOP), .SEL_BOT(SEL_EXM_BOT)) u_ex_top (
    .src(id_src_top), .src_vld(id_src_top_vld), .tag(ex_tag),
    .sel(ex_top_sel), .hit(ex_top_hit));

  fwd_match #(.SEL_TOP(SEL_EXM_TOP), .SEL_BOT(SEL_EXM_BOT)) u_ex_bot (
    .src(id_src_bot), .src_vld(id_src_bot_vld), .tag(ex_tag),
    .sel(ex_bot_sel), .hit(ex_bot_hit));

  fwd_match #(.SEL_TOP(SEL_MWB_TOP), .SEL_BOT(SEL_MWB_BOT)) u_mem_top (
    .src(id_src_top), .src_vld(id_src_top_vld), .tag(mem_tag),
    .sel(mem_top_sel), .hit(mem_top_hit));

  fwd_match #(.SEL_TOP(SEL_MWB_TOP), .SEL_BOT(SEL_MWB_BOT)) u_mem_bot (
    .src(id_src_bot), .src_vld(id_src_bot_vld), .tag(mem_tag),
    .sel(mem_bot_sel), .hit(mem_bot_hit));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    top_sel_d = SEL_ID_EX;
    bot_sel_d = SEL_ID_EX;
    if (ex_top_hit)       top_sel_d = ex_top_sel;
    else if (mem_top_hit) top_sel_d = mem_top_sel;
    if (ex_bot_hit)       bot_sel_d = ex_bot_sel;
    else if (mem_bot_hit) bot_sel_d = mem_bot_sel;
  end

  // A load result is not ready until after MEM, so an EX-tag load hit must wait a cycle.
  assign stall = !rst && id_valid && !mem_hold && !flush &&
                 ex_tag.valid && ex_tag.is_load && (ex_top_hit || ex_bot_hit);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag    <= TAG_EMPTY;
      mem_tag   <= TAG_EMPTY;
      wb_tag    <= TAG_EMPTY;
      top_sel_q <= SEL_ID_EX;
      bot_sel_q <= SEL_ID_EX;
      bubble    <= 1'b1;
    end else if (!mem_hold) begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      if (flush || stall || !id_valid) begin
        ex_tag    <= TAG_EMPTY;
        top_sel_q <= SEL_ID_EX;
        bot_sel_q <= SEL_ID_EX;
        bubble    <= 1'b1;
      end else begin
        ex_tag    <= id_tag;
        top_sel_q <= top_sel_d;
        bot_sel_q <= bot_sel_d;
        bubble    <= 1'b0;
      end
    end
  end

  assign alu_top_sel = top_sel_q;
  assign alu_bot_sel = bot_sel_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed, table-driven bench for forwarding_hazard_unit: each record is one cycle of
// ID inputs with the expected combinational stall and the post-edge registered outputs.
module tb_forwarding_hazard_unit;

  localparam logic [4:0] IDEX = 5'b00001;
  localparam logic [4:0] EXT  = 5'b00010;
  localparam logic [4:0] EXB  = 5'b00100;
  localparam logic [4:0] MWT  = 5'b01000;
  localparam logic [4:0] MWB  = 5'b10000;
  localparam int         X    = -1;

  typedef struct {
    logic       rst;
    logic       id_valid;
    logic [4:0] st;
    logic       stv;
    logic [4:0] sb;
    logic       sbv;
    logic [4:0] dt;
    logic       dtv;
    logic [4:0] db;
    logic       dbv;
    logic       ld;
    logic       fl;
    logic       hd;
    logic       exp_stall;
    logic [4:0] exp_top;
    logic [4:0] exp_bot;
    logic       exp_bubble;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src_top, id_src_bot, id_dst_top, id_dst_bot;
  logic       id_src_top_vld, id_src_bot_vld, id_dst_top_vld, id_dst_bot_vld;
  logic       id_is_load, flush, mem_hold;
  logic [4:0] alu_top_sel, alu_bot_sel;
  logic       stall, bubble;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_top(id_src_top), .id_src_top_vld(id_src_top_vld),
    .id_src_bot(id_src_bot), .id_src_bot_vld(id_src_bot_vld),
    .id_dst_top(id_dst_top), .id_dst_top_vld(id_dst_top_vld),
    .id_dst_bot(id_dst_bot), .id_dst_bot_vld(id_dst_bot_vld),
    .id_is_load(id_is_load), .flush(flush), .mem_hold(mem_hold),
    .alu_top_sel(alu_top_sel), .alu_bot_sel(alu_bot_sel),
    .stall(stall), .bubble(bubble));

  // Register fields given as X are marked invalid but still carry r3, so a broken
  // qualifier check shows up as a false match against the r3 producers.
  function automatic vec_t mk(bit r, bit v, int st, int sb, int dt, int db,
                              bit ld, bit fl, bit hd,
                              bit es, logic [4:0] et, logic [4:0] eb, bit ebub);
    vec_t t;
    t.rst = r;  t.id_valid = v;
    t.stv = (st >= 0); t.st = t.stv ? st[4:0] : 5'd3;
    t.sbv = (sb >= 0); t.sb = t.sbv ? sb[4:0] : 5'd3;
    t.dtv = (dt >= 0); t.dt = t.dtv ? dt[4:0] : 5'd3;
    t.dbv = (db >= 0); t.db = t.dbv ? db[4:0] : 5'd3;
    t.ld = ld; t.fl = fl; t.hd = hd;
    t.exp_stall = es; t.exp_top = et; t.exp_bot = eb; t.exp_bubble = ebub;
    return t;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    rst = t.rst; id_valid = t.id_valid;
    id_src_top = t.st; id_src_top_vld = t.stv;
    id_src_bot = t.sb; id_src_bot_vld = t.sbv;
    id_dst_top = t.dt; id_dst_top_vld = t.dtv;
    id_dst_bot = t.db; id_dst_bot_vld = t.dbv;
    id_is_load = t.ld; flush = t.fl; mem_hold = t.hd;
    #1;
    check({tag, " stall"}, {4'b0, stall}, {4'b0, t.exp_stall});
    @(posedge clk);
    #1;
    check({tag, " top_sel"}, alu_top_sel, t.exp_top);
    check({tag, " bot_sel"}, alu_bot_sel, t.exp_bot);
    check({tag, " bubble"}, {4'b0, bubble}, {4'b0, t.exp_bubble});
  endtask

  vec_t tbl [15];

  initial begin
    //              rst v  st  sb  dt  db  ld fl hd  stall top   bot   bub
    tbl[0]  = mk(1, 1,  1,  2,  3,  X, 1, 1, 1,  0,  IDEX, IDEX, 1); // reset beats hold/flush
    tbl[1]  = mk(0, 1,  1,  2,  3,  X, 0, 0, 0,  0,  IDEX, IDEX, 0); // ADD r3<-r1,r2
    tbl[2]  = mk(0, 1,  3,  5,  4,  X, 0, 0, 0,  0,  EXT,  IDEX, 0); // ADD r4<-r3,r5
    tbl[3]  = mk(0, 1,  3,  X,  8,  X, 0, 0, 0,  0,  MWT,  IDEX, 0); // r3 two back
    tbl[4]  = mk(0, 1,  X,  X,  X,  6, 1, 0, 0,  0,  IDEX, IDEX, 0); // LOAD r6
    tbl[5]  = mk(0, 1,  3,  6,  9,  X, 0, 0, 0,  1,  IDEX, IDEX, 1); // use r6: stall
    tbl[6]  = mk(0, 1,  3,  6,  9,  X, 0, 0, 0,  0,  IDEX, MWB,  0); // replay after stall
    tbl[7]  = mk(0, 1,  X,  X,  X,  7, 0, 0, 0,  0,  IDEX, IDEX, 0); // bot writes r7
    tbl[8]  = mk(0, 1,  X,  X,  7,  0, 0, 0, 0,  0,  IDEX, IDEX, 0); // top r7, bot r0
    tbl[9]  = mk(0, 1,  7,  0, 10, 10, 0, 0, 0,  0,  EXT,  IDEX, 0); // EX beats MEM, r0
    tbl[10] = mk(0, 1, 10,  X,  X,  X, 0, 0, 0,  0,  EXB,  IDEX, 0); // top==bot -> bot
    tbl[11] = mk(0, 1,  X,  X, 11,  X, 1, 0, 0,  0,  IDEX, IDEX, 0); // LOAD r11
    tbl[12] = mk(0, 1, 11, 10,  X,  X, 0, 1, 0,  0,  IDEX, IDEX, 1); // flush beats stall
    tbl[13] = mk(0, 0, 11, 10,  X,  X, 0, 0, 0,  0,  IDEX, IDEX, 1); // idle slot
    tbl[14] = mk(0, 1, 11, 10,  X,  X, 0, 0, 0,  0,  IDEX, IDEX, 0); // WB not forwarded

    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Load-use hazard frozen by mem_hold for three cycles, then resolved.
    step(mk(1, 0, X, X, X, X, 0, 0, 0, 0, IDEX, IDEX, 1), "hold_rst");
    step(mk(0, 1, X, X, 2, X, 0, 0, 0, 0, IDEX, IDEX, 0), "hold_prod");
    step(mk(0, 1, 2, X, X, 6, 1, 0, 0, 0, EXT,  IDEX, 0), "hold_load");
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, X, 6, X, X, 0, 0, 1, 0, EXT, IDEX, 0), $sformatf("hold%0d", i));
    step(mk(0, 1, X, 6, X, X, 0, 0, 0, 1, IDEX, IDEX, 1), "hold_release");
    step(mk(0, 1, X, 6, X, X, 0, 0, 0, 0, IDEX, MWB,  0), "hold_fwd");

    // Reset arriving while a load-use stall is pending drops the hazard.
    step(mk(0, 1, X, X, X, 6, 1, 0, 0, 0, IDEX, IDEX, 0), "rst_load");
    step(mk(1, 1, 6, 6, X, X, 0, 0, 0, 0, IDEX, IDEX, 1), "rst_mid_stall");
    step(mk(0, 1, 6, 6, X, X, 0, 0, 0, 0, IDEX, IDEX, 0), "rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clock input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have these inputs:
- id_valid, 1 bit: ID holds a valid instruction.
- id_src_top, 5 bits, with id_src_top_vld, 1 bit: ID top-operand source register and its qualifier.
- id_src_bot, 5 bits, with id_src_bot_vld, 1 bit: bottom-operand source register and its qualifier.
- id_dst_top, 5 bits, with id_dst_top_vld, 1 bit: register written from alu_out[15:8] and its qualifier.
- id_dst_bot, 5 bits, with id_dst_bot_vld, 1 bit: register written from alu_out[7:0] and its qualifier.
- id_is_load, 1 bit: result is known only after MEM.
- flush, 1 bit: discard ID and EX contents.
- mem_hold, 1 bit: freeze the whole pipeline.
REQ-003 SHALL have these outputs:
- alu_top_sel, 5 bits: registered ALU top-input select.
- alu_bot_sel, 5 bits: registered ALU bottom-input select.
- stall, 1 bit: combinational; holds the PC and the IF/ID register.
- bubble, 1 bit: registered; the instruction in EX is a NOP.

Function
REQ-004 Select encoding SHALL be one-hot: SEL_ID_EX=00001, SEL_EXM_TOP=00010, SEL_EXM_BOT=00100, SEL_MWB_TOP=01000, SEL_MWB_BOT=10000.
REQ-005 The unit SHALL keep shadow tags for the EX, MEM and WB stages; each tag is {valid, dst_top, dst_top_vld, dst_bot, dst_bot_vld, is_load}.
REQ-006 On an advance edge (id_valid, ~stall, ~mem_hold), the ID fields SHALL load into the EX tag, EX into MEM, and MEM into WB.
REQ-007 On a stall edge (stall=1, ~mem_hold), the EX tag SHALL become invalid, MEM SHALL take EX, WB SHALL take MEM, and bubble SHALL go to 1.
REQ-008 With id_valid=0 and no hold, the unit SHALL advance as in REQ-006 with an invalid EX tag, and bubble SHALL go to 1.
REQ-009 While mem_hold=1, all tags, selects and bubble SHALL hold their values and stall SHALL be 0.
REQ-010 Select computation SHALL happen in the cycle an instruction sits in ID. A valid source is compared against the current EX tag (the producer that will be in EX/MEM when the consumer reaches EX) and the current MEM tag (the producer that will be in MEM/WB). The result SHALL be registered into alu_*_sel on the advance edge.
REQ-011 Priority SHALL be: EX-tag match over MEM-tag match over SEL_ID_EX. Within one tag, a dst_top match selects *_TOP, else a dst_bot match selects *_BOT.
REQ-012 A tag with dst_top == dst_bot and both qualifiers valid SHALL resolve to *_BOT (the later write wins).
REQ-013 Register 0 SHALL never match; a source of 0, or a source with its qualifier clear, SHALL select SEL_ID_EX.
REQ-014 stall SHALL be 1 when id_valid, ~mem_hold, the EX tag is valid with is_load=1, and either valid ID source matches its dst_top or dst_bot.
REQ-015 A load-use hazard SHALL stall for exactly one cycle; on the following cycle the load is in the MEM tag and forwarding SHALL use SEL_MWB_*.
REQ-016 flush SHALL clear the EX tag valid bit and set bubble=1 on the next edge. MEM/WB SHALL still shift, and stall SHALL be forced to 0. flush SHALL take precedence over stall, but mem_hold SHALL take precedence over flush.
REQ-017 Invalid tags SHALL never match.
REQ-018 Select latency SHALL be one clock edge from ID to EX, with no combinational path from id_* to alu_*_sel.

Reset
REQ-019 While reset=1 at a clock edge: all tag valid bits SHALL go to 0, alu_top_sel and alu_bot_sel SHALL go to SEL_ID_EX, and bubble SHALL go to 1.
REQ-020 stall SHALL be 0 during reset, and reset SHALL override mem_hold and flush.
REQ-021 A reset mid-stall SHALL drop the pending hazard; the first post-reset instruction SHALL see no forwarding.

Structure
REQ-022 The SEL_* encodings, the stage-tag field layout and the register-0 constant SHALL live in the shared pipeline package, which alu_input_mux also consumes.
REQ-023 A single sub-module, fwd_match (one source vs one tag, returning a 5-bit select and a hit), SHALL be instantiated four times: 2 sources × 2 tags.

Verification
REQ-024 ADD r3←r1,r2, then ADD r4←r3,r5 back-to-back -> second instruction: alu_top_sel=00010, alu_bot_sel=00001, no stall.
REQ-025 Producer writing r3, one unrelated instruction, then consumer of r3 -> consumer alu_top_sel=01000.
REQ-026 LOAD r6 followed immediately by consumer of r6 (bot) -> stall=1 for one cycle with bubble=1; then alu_bot_sel=10000.
REQ-027 Two producers both writing r7 (EX and MEM tags) -> select=00010 (EX/MEM wins); a source of r0 -> 00001.
REQ-028 mem_hold=1 for 3 cycles during a load-use hazard -> stall=0 and all outputs frozen; after release the stall resolves as in REQ-026.
REQ-029 reset asserted during a stall, or flush while a load is in EX -> selects=00001, bubble=1, no further stall.
